lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/lsu.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding common to the ALU and the LSU, plus
// the writes-register predicate reused by the hazard logic.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_LW   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_BGT  = 4'd12;
  localparam logic [3:0] OP_BGE  = 4'd13;
  localparam logic [3:0] OP_JMP  = 4'd14;

  // Opcodes that produce a register result (before the rd != 0 qualification).
  function automatic logic writes_reg(input logic [3:0] op);
    logic w;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LW: w = 1'b1;
      default:                               w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/lsu.sv
// Load/store unit: single FSM that issues one memory request per LW/SW and
// retires every accepted instruction exactly once through the writeback port.
module lsu
  import cpu_pkg::*;
#(
  parameter int DATAWIDTH    = 32,
  parameter int REGADDRWIDTH = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [3:0]              opcode_i,
  input  logic [DATAWIDTH-1:0]    alu_out_i,
  input  logic [DATAWIDTH-1:0]    store_data_i,
  input  logic [REGADDRWIDTH-1:0] rd_i,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATAWIDTH-1:0]    mem_addr_o,
  output logic [DATAWIDTH-1:0]    mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATAWIDTH-1:0]    mem_rdata_i,
  output logic                    wb_valid_o,
  output logic                    wb_we_o,
  output logic [REGADDRWIDTH-1:0] wb_rd_o,
  output logic [DATAWIDTH-1:0]    wb_data_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RETIRE} lsu_state_e;

  lsu_state_e              state_q, state_d;
  logic [DATAWIDTH-1:0]    addr_q, addr_d;
  logic [DATAWIDTH-1:0]    wdata_q, wdata_d;
  logic                    store_q, store_d;
  logic                    wr_q, wr_d;
  logic [REGADDRWIDTH-1:0] rd_q, rd_d;
  logic [REGADDRWIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [DATAWIDTH-1:0]    wb_data_q, wb_data_d;

  // Next-state and capture logic; wb_rd/wb_data only change when entering RETIRE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    store_d   = store_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          wr_d = writes_reg(opcode_i) && (rd_i != '0);
          if (is_mem_op(opcode_i)) begin
            state_d = REQ;
            addr_d  = {alu_out_i[DATAWIDTH-1:2], 2'b00};
            wdata_d = store_data_i;
            store_d = (opcode_i == OP_SW);
            rd_d    = rd_i;
          end else begin
            state_d   = RETIRE;
            wb_rd_d   = rd_i;
            wb_data_d = alu_out_i;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          if (store_q) begin
            state_d   = RETIRE;
            wb_rd_d   = rd_q;
            wb_data_d = '0;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d   = RETIRE;
          wb_rd_d   = rd_q;
          wb_data_d = mem_rdata_i;
        end else begin
          state_d = WAIT;
        end
      end
      RETIRE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; reset returns to IDLE from any state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      store_q   <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      store_q   <= store_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = (state_q == REQ) && store_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign wb_valid_o  = (state_q == RETIRE);
  assign wb_we_o     = (state_q == RETIRE) && wr_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;

endmodule
